// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, sequencer states and
// instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_LOAD    = 4'hA;
  localparam logic [3:0] OP_STORE   = 4'hB;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_BZ      = 4'hD;
  localparam logic [3:0] OP_JR      = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_ALU_MAX;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the executee datapath and the shared
// 16-bit memory port. Outputs are Moore-decoded except the mem_ready strobes.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [3:0] PASS_A_OP = 4'h0,
  parameter logic [3:0] PASS_B_OP = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] irout,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_ready,
  output logic        en,
  output logic        sel,
  output logic        pc_sel,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        ir_load,
  output logic        add_sel,
  output logic [2:0]  write_add,
  output logic [2:0]  fir_add,
  output logic [2:0]  sec_add,
  output logic [3:0]  opcode,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic [2:0]  flags
);

  state_t     state_q, state_d;
  logic [2:0] flags_q;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic       unused_ir;

  assign op  = irout[OP_HI:OP_LO];
  assign rd  = irout[RD_HI:RD_LO];
  assign rs1 = irout[RS1_HI:RS1_LO];
  assign rs2 = irout[RS2_HI:RS2_LO];
  // Low bits only matter to the datapath's branch-offset sign extension.
  assign unused_ir = ^irout[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EXEC && is_alu_op(op))
        flags_q <= {C, N, Z};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_LOAD || op == OP_STORE) state_d = ST_MEM;
        else if (op == OP_HALT)              state_d = ST_HALT;
        else                                 state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_MEM:    if (mem_ready) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    en        = 1'b0;
    sel       = 1'b0;
    pc_sel    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    add_sel   = 1'b0;
    write_add = 3'd0;
    fir_add   = 3'd0;
    sec_add   = 3'd0;
    opcode    = 4'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end
        ST_EXEC: begin
          if (is_alu_op(op)) begin
            en        = 1'b1;
            write_add = rd;
            fir_add   = rs1;
            sec_add   = rs2;
            opcode    = op;
          end else begin
            case (op)
              OP_JMP: pc_load = 1'b1;
              OP_BZ:  pc_load = flags_q[0];
              OP_JR: begin
                fir_add = rs1;
                opcode  = PASS_A_OP;
                pc_sel  = 1'b1;
                pc_load = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          add_sel = 1'b1;
          fir_add = rs1;
          mem_req = 1'b1;
          if (op == OP_STORE) begin
            mem_we  = 1'b1;
            sec_add = rs2;
            opcode  = PASS_B_OP;
          end else if (mem_ready) begin
            en        = 1'b1;
            sel       = 1'b1;
            write_add = rd;
          end
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign flags = rst ? 3'b000 : flags_q;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer that drives the control inputs of the `executee` datapath and the instruction/data memory handshake. It consumes the datapath's instruction register and ALU flags, and produces register-file addresses, ALU opcode, PC/IR strobes, address-mux select and memory requests. It sits beside `executee` in the processor top; memory is a single shared 16-bit port.

## Interface
Parameters:
- `PASS_A_OP`, default 4'h0: ALU opcode making `dataout` = register[fir_add], used by JR.
- `PASS_B_OP`, default 4'h1: ALU opcode making `dataout` = register[sec_add], used by STORE.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `irout` in 16: instruction register from the datapath.
- `C`, `N`, `Z` in 1 each: combinational ALU flags from the datapath.
- `mem_ready` in 1: memory completes the current request this cycle.
- `en`, `sel`, `pc_sel`, `pc_load`, `pc_inc`, `ir_load`, `add_sel` out 1 each: datapath controls.
- `write_add`, `fir_add`, `sec_add` out 3 each: register addresses.
- `opcode` out 4: ALU opcode.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `halted` out 1: high in HALT.
- `flags` out 3: registered {C,N,Z}.

## Operation
- Encoding: op=ir[15:12], rd=ir[11:9], rs1=ir[8:6], rs2=ir[5:3]. The branch offset ir[7:0] is sign-extended by the datapath.
- Opcodes:
  - 0x0–0x9: ALU.
  - 0xA: LOAD, rd←mem[rs1].
  - 0xB: STORE, mem[rs1]←rs2.
  - 0xC: JMP, PC+off.
  - 0xD: BZ, branch taken if registered Z=1.
  - 0xE: JR, PC←rs1.
  - 0xF: HALT.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - Drive `mem_req`=1, `add_sel`=0.
  - When `mem_ready`=1: drive `ir_load`=1 and `pc_inc`=1 that cycle, then go to DECODE. Otherwise stay.
- DECODE: one cycle with no strobes. The next state is MEM for 0xA/0xB, HALT for 0xF, and EXEC otherwise.
- EXEC:
  - ALU op: `en`=1, `sel`=0, `write_add`=rd, `fir_add`=rs1, `sec_add`=rs2, `opcode`=op. `flags` ← {C,N,Z} at the edge.
  - JMP: `pc_sel`=0, `pc_load`=1.
  - BZ: `pc_load`=flags[0] (Z), `pc_sel`=0.
  - JR: `fir_add`=rs1, `opcode`=PASS_A_OP, `pc_sel`=1, `pc_load`=1.
  - Always returns to FETCH.
- MEM:
  - Drive `add_sel`=1, `fir_add`=rs1, `mem_req`=1.
  - LOAD: `mem_we`=0. On `mem_ready`, drive `en`=1, `sel`=1 (din), `write_add`=rd.
  - STORE: `mem_we`=1, `sec_add`=rs2, `opcode`=PASS_B_OP.
  - Goes to FETCH on `mem_ready`, otherwise stays.
- HALT: absorbing; `halted`=1, all strobes 0. Exit only through `rst`.
- `flags` updates only on EXEC of opcodes 0x0–0x9. LOAD, STORE and branches leave it unchanged.
- The branch target is relative to the already-incremented PC.

## Timing
- All outputs are Moore-decoded from state and `irout`. The exceptions are the `mem_ready`-qualified strobes (`ir_load`, `pc_inc`, `en` for LOAD), which are combinational on `mem_ready`.
- Reset:
  - Applies on any cycle, including mid-MEM or HALT.
  - Next state is FETCH, `flags`=0.
  - All outputs are 0 while `rst`=1. `mem_req` rises the cycle after `rst` falls.
- Latency with zero-wait memory:
  - ALU/JMP/BZ/JR: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD/STORE: 3 cycles (FETCH, DECODE, MEM).
  - Each memory wait cycle adds 1.
- `mem_ready` outside FETCH/MEM is ignored.
- While waiting, `mem_req`, `mem_we` and the address controls hold stable until `mem_ready`.
- Exactly one `pc_inc` per instruction. `pc_load` and `pc_inc` are never high together.

## Structure
- A shared package `cpu_pkg` holds:
  - the opcode localparams (OP_LOAD=4'hA … OP_HALT=4'hF);
  - the state encoding (3-bit: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4);
  - the field-slice constants.
- Single module; no sub-module. The flag register and the state register live inline.

## Test plan
- Reset, then feed 0x0A50 (ALU op0, rd=5, rs1=1, rs2=2) with `mem_ready`=1. Expect FETCH→DECODE→EXEC, and in EXEC `en`=1, `write_add`=5, `fir_add`=1, `sec_add`=2, `opcode`=0. The next cycle shows `mem_req`=1.
- LOAD 0xA680 with `mem_ready` low for 3 MEM cycles. Expect `add_sel`=1, `fir_add`=2, `mem_req` held for 4 cycles, then `en`=1, `sel`=1, `write_add`=3 only in the ready cycle.
- STORE 0xB0D0 (rs1=3, rs2=2). Expect `mem_we`=1, `fir_add`=3, `sec_add`=2, `opcode`=PASS_B_OP, and `en`=0 throughout.
- BZ 0xD0FE:
  - With flags Z=1: `pc_load`=1, `pc_sel`=0.
  - With Z=0: `pc_load`=0.
  - JR 0xE080: `pc_sel`=1, `pc_load`=1, `fir_add`=2.
- HALT 0xF000. Expect `halted`=1 with no further `mem_req` for 20 cycles. Then assert `rst` mid-MEM of a LOAD: the next cycle is FETCH, all strobes 0, `flags`=0.
